weighted_rr_arbiter: RTL and testbench

//  Parametrised weighted round-robin arbiter with a grant/acknowledge handshake.

---
 rtl/weighted_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_weighted_rr_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with registered grant held until acknowledged.
// Optional grant watchdog enabled by defining WRR_TIMEOUT_EN.
module weighted_rr_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned M      = (N > 2) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_weight,
    input  logic           i_ack,
    output logic [N-1:0]   o_gnt,
    output logic [M-1:0]   o_gnt_id,
    output logic           o_valid,
    output logic           o_timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [M-1:0]   gnt_id_q, gnt_id_d;
    logic           valid_q, valid_d;
    logic           timeout_q, timeout_d;
    logic [M-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   credit_q [N];
    logic [W-1:0]   credit_d [N];

    logic [N-1:0]   elig;
    logic           any_elig;
    logic [M-1:0]   win_id;
    logic [M-1:0]   next_id;
    logic [W-1:0]   credit_dec;

`ifdef WRR_TIMEOUT_EN
    localparam int unsigned WT = $clog2(TIMEOUT + 1);
    logic [WT-1:0]  cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            elig[i] = i_req[i] && (credit_q[i] != '0);
        end
    end

    // Descending scan so the smallest offset from ptr is the last, winning assignment.
    always_comb begin
        any_elig = 1'b0;
        win_id   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (elig[(int'(ptr_q) + k) % int'(N)]) begin
                any_elig = 1'b1;
                win_id   = M'((int'(ptr_q) + k) % int'(N));
            end
        end
    end

    assign next_id    = (gnt_id_q == M'(N - 1)) ? '0 : gnt_id_q + M'(1);
    assign credit_dec = (credit_q[gnt_id_q] != '0) ? credit_q[gnt_id_q] - W'(1) : '0;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        credit_d  = credit_q;
`ifdef WRR_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                valid_d  = 1'b0;
                if (any_elig) begin
                    state_d  = StGrant;
                    gnt_d    = {{(N-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_d = win_id;
                    valid_d  = 1'b1;
`ifdef WRR_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else if (|i_req) begin
                    // Round boundary: reload every credit, zero weight counts as one.
                    for (int i = 0; i < int'(N); i++) begin
                        credit_d[i] = (i_weight[i*W +: W] == '0) ? W'(1) : i_weight[i*W +: W];
                    end
                end
            end
            StGrant: begin
                if (i_ack) begin
                    state_d            = StIdle;
                    gnt_d              = '0;
                    gnt_id_d           = '0;
                    valid_d            = 1'b0;
                    credit_d[gnt_id_q] = credit_dec;
                    ptr_d              = (credit_dec != '0) ? gnt_id_q : next_id;
                end
`ifdef WRR_TIMEOUT_EN
                else if (cnt_q == WT'(TIMEOUT - 1)) begin
                    state_d            = StIdle;
                    gnt_d              = '0;
                    gnt_id_d           = '0;
                    valid_d            = 1'b0;
                    timeout_d          = 1'b1;
                    credit_d[gnt_id_q] = '0;
                    ptr_d              = next_id;
                end else begin
                    cnt_d = cnt_q + WT'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            credit_q  <= '{default: '0};
`ifdef WRR_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
`ifdef WRR_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_id  = gnt_id_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Self-checking bench for weighted_rr_arbiter (N=8, W=4, TIMEOUT=16).
// Expected grants are queued when stimulus is set up and popped as grants appear.
module tb_weighted_rr_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [7:0]  i_req;
    logic [31:0] i_weight;
    logic        i_ack;
    logic [7:0]  o_gnt;
    logic [2:0]  o_gnt_id;
    logic        o_valid;
    logic        o_timeout;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q [$];

    weighted_rr_arbiter #(
        .N       (8),
        .W       (4),
        .TIMEOUT (16)
    ) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_req     (i_req),
        .i_weight  (i_weight),
        .i_ack     (i_ack),
        .o_gnt     (o_gnt),
        .o_gnt_id  (o_gnt_id),
        .o_valid   (o_valid),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [2:0] id_of(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic do_reset();
        i_rstn   = 1'b0;
        i_req    = '0;
        i_ack    = 1'b0;
        i_weight = '0;
        exp_q.delete();
        repeat (2) tick();
        i_rstn = 1'b1;
        tick();
    endtask

    // Waits (bounded) for each grant, checks it against the queue, then acknowledges.
    task automatic serve(input int n, input int hold, input bit chk_gap);
        logic [7:0] exp;
        int w;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (o_valid !== 1'b1 && w < 8) begin
                tick();
                w++;
            end
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            checks++;
            if (o_gnt !== exp) begin
                fails++;
                $display("FAIL grant_vec[%0d]: got %h expected %h", k, o_gnt, exp);
            end
            checks++;
            if (o_gnt_id !== id_of(exp)) begin
                fails++;
                $display("FAIL grant_id[%0d]: got %0d expected %0d", k, o_gnt_id, id_of(exp));
            end
            if (chk_gap && k > 0) begin
                checks++;
                if (w != 1) begin
                    fails++;
                    $display("FAIL idle_gap[%0d]: got %0d expected 1", k, w);
                end
            end
            repeat (hold) tick();
            i_ack = 1'b1;
            tick();
            i_ack = 1'b0;
            checks++;
            if (o_valid !== 1'b0 || o_gnt !== 8'h00) begin
                fails++;
                $display("FAIL release[%0d]: got valid=%b gnt=%h expected 0/00", k, o_valid, o_gnt);
            end
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        i_req  = 8'hFF;
        i_ack  = 1'b0;
        #3;
        checks++;
        if ({o_gnt, o_gnt_id, o_valid, o_timeout} !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%h id=%0d v=%b to=%b expected all 0",
                     o_gnt, o_gnt_id, o_valid, o_timeout);
        end
        do_reset();
        i_ack = 1'b1;
        repeat (3) tick();
        i_ack = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_ack_ignored: got valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_single_weight();
        do_reset();
        i_weight[3:0] = 4'd3;
        i_req = 8'h01;
        repeat (6) exp_q.push_back(8'h01);
        serve(6, 1, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        i_weight[3:0]   = 4'd2;
        i_weight[31:28] = 4'd1;
        i_req = 8'h81;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h80);
        end
        serve(6, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_req = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
        serve(8, 0, 1'b1);
        exp_q.push_back(8'h01);
        serve(1, 0, 1'b0);
    endtask

    task automatic test_hold();
        int w;
        do_reset();
        i_req = 8'h04;
        w = 0;
        while (o_valid !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) i_req = 8'h00;
            tick();
            checks++;
            if (o_gnt !== 8'h04) begin
                fails++;
                $display("FAIL hold[%0d]: got %h expected 04", c, o_gnt);
            end
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: got valid=%b expected 0", o_valid);
        end
    endtask

    task automatic test_async_reset();
        int w;
        do_reset();
        i_req = 8'h02;
        exp_q.push_back(8'h02);
        serve(1, 0, 1'b0);
        i_req = 8'h04;
        w = 0;
        while (o_valid !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        checks++;
        if (o_gnt !== 8'h04) begin
            fails++;
            $display("FAIL pre_reset_grant: got %h expected 04", o_gnt);
        end
        #2;
        i_rstn = 1'b0;
        #1;
        checks++;
        if (o_gnt !== 8'h00 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got gnt=%h valid=%b expected 00/0", o_gnt, o_valid);
        end
        tick();
        i_rstn = 1'b1;
        i_req  = 8'h05;
        exp_q.push_back(8'h01);
        serve(1, 0, 1'b0);
    endtask

    task automatic test_timeout();
        int w;
        do_reset();
        i_req = 8'h03;
        w = 0;
        while (o_valid !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        checks++;
        if (o_gnt !== 8'h01) begin
            fails++;
            $display("FAIL to_first_grant: got %h expected 01", o_gnt);
        end
`ifdef WRR_TIMEOUT_EN
        w = 0;
        while (o_timeout !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (w != 16 || o_gnt !== 8'h00) begin
            fails++;
            $display("FAIL to_pulse: got %0d cycles gnt=%h expected 16 cycles gnt=00", w, o_gnt);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b0 || o_gnt !== 8'h02) begin
            fails++;
            $display("FAIL to_next: got to=%b gnt=%h expected 0/02", o_timeout, o_gnt);
        end
`else
        w = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (o_gnt !== 8'h01 || o_timeout !== 1'b0) w++;
        end
        checks++;
        if (w != 0) begin
            fails++;
            $display("FAIL no_timeout_hold: got %0d bad cycles expected 0", w);
        end
`endif
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_weight();
        test_wrap();
        test_back_to_back();
        test_hold();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
